// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock through a
// ripple chain of full adders; sum/cout/ovf are published together on entry to DONE.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             chain_c_s;
    logic             msb_cin_s;

    // Ripple chain over the lowest unprocessed digit; msb_cin_s is the carry into its top bit.
    always_comb begin
        dig_s     = {DIGIT{1'b0}};
        chain_c_s = carry_q;
        msb_cin_s = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            msb_cin_s = chain_c_s;
            dig_s[i]  = a_q[i] ^ b_q[i] ^ chain_c_s;
            chain_c_s = (a_q[i] & b_q[i]) | (chain_c_s & (a_q[i] ^ b_q[i]));
        end
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, so the inversion and carry seed happen at latch time.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain_c_s;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                if (cnt_q == LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = res_d;
                    cout_d  = chain_c_s;
                    ovf_d   = chain_c_s ^ msb_cin_s;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at DIGIT = 4, 1 and 16 (WIDTH = 16),
// all three instances sharing the same stimulus.
module tb_serial_addsub;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        sub_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        cin_i;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [15:0] sum_v [3];

    int errors = 0;
    int checks = 0;

    // per-instance observations from run_op: index 0 = DIGIT 4, 1 = DIGIT 1, 2 = DIGIT 16
    int          lat_r  [3];
    int          busy_n [3];
    int          done_n [3];
    logic [15:0] sum_r  [3];
    logic        cout_r [3];
    logic        ovf_r  [3];
    int          exp_lat  [3] = '{5, 17, 2};
    int          exp_busy [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst_i), .start(start_i), .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst_i), .start(start_i), .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst_i), .start(start_i), .sub(sub_i), .a(a_i), .b(b_i), .cin(cin_i),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge and watch all instances for 20 cycles (bounded wait).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tc);
        a_i = ta; b_i = tb_v; sub_i = ts; cin_i = tc; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lat_r[k] = 0; busy_n[k] = 0; done_n[k] = 0;
            sum_r[k] = 16'h0000; cout_r[k] = 1'b0; ovf_r[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (busy_v[k]) busy_n[k]++;
                if (done_v[k]) begin
                    done_n[k]++;
                    if (lat_r[k] == 0) begin
                        lat_r[k] = cyc + 1;
                        sum_r[k] = sum_v[k]; cout_r[k] = cout_v[k]; ovf_r[k] = ovf_v[k];
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; sub_i = 1'b0; a_i = 16'h0000; b_i = 16'h0000; cin_i = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_v[k], done_v[k], cout_v[k], ovf_v[k]} !== 4'b0000 || sum_v[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset[%0d]: got busy=%b done=%b sum=%h cout=%b ovf=%b want all zero",
                         k, busy_v[k], done_v[k], sum_v[k], cout_v[k], ovf_v[k]);
            end
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (busy_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 000 000", busy_v, done_v);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'h0001, 16'h7FFF, 16'h0005, 16'h8000};
        logic [15:0] vb [4] = '{16'hFFFF, 16'h0001, 16'h0007, 16'h0001};
        logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] es [4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic        ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int v = 0; v < 4; v++) begin
            run_op(va[v], vb[v], vs[v], vc[v]);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_n[k] !== 1) begin
                    errors++;
                    $display("FAIL dir_done_count[%0d] v%0d: got %0d want 1", k, v, done_n[k]);
                end
                checks++;
                if (lat_r[k] !== exp_lat[k]) begin
                    errors++;
                    $display("FAIL dir_latency[%0d] v%0d: got %0d want %0d", k, v, lat_r[k], exp_lat[k]);
                end
                checks++;
                if (busy_n[k] !== exp_busy[k]) begin
                    errors++;
                    $display("FAIL dir_busy_cycles[%0d] v%0d: got %0d want %0d", k, v, busy_n[k], exp_busy[k]);
                end
                checks++;
                if (sum_r[k] !== es[v] || cout_r[k] !== ec[v] || ovf_r[k] !== eo[v]) begin
                    errors++;
                    $display("FAIL dir_result[%0d] v%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                             k, v, sum_r[k], cout_r[k], ovf_r[k], es[v], ec[v], eo[v]);
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        int          nd = 0;
        logic [15:0] s1 = 16'h0000;
        logic        c1 = 1'b0;
        logic        o1 = 1'b0;
        a_i = 16'h1234; b_i = 16'h1111; sub_i = 1'b0; cin_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (sum_v[0] !== 16'h7FFF) begin
            errors++;
            $display("FAIL sum_held_in_run: got %h want 7fff", sum_v[0]);
        end
        tick();
        a_i = 16'hFFFF; b_i = 16'h0F0F; sub_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int cyc = 2; cyc < 14; cyc++) begin
            if (done_v[0]) begin
                nd++;
                s1 = sum_v[0]; c1 = cout_v[0]; o1 = ovf_v[0];
            end
            tick();
        end
        checks++;
        if (nd !== 1) begin
            errors++;
            $display("FAIL start_in_run_done_count: got %0d want 1", nd);
        end
        checks++;
        if (s1 !== 16'h2345 || c1 !== 1'b0 || o1 !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run_result: got sum=%h cout=%b ovf=%b want sum=2345 cout=0 ovf=0", s1, c1, o1);
        end
        repeat (25) tick();
    endtask

    task automatic test_rst_abort();
        int nd = 0;
        a_i = 16'h0001; b_i = 16'h0002; sub_i = 1'b0; cin_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (busy_v !== 3'b000 || done_v !== 3'b000) begin
            errors++;
            $display("FAIL abort_flags: got busy=%b done=%b want 000 000", busy_v, done_v);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sum_v[k] !== 16'h0000 || cout_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
                errors++;
                $display("FAIL abort_cleared[%0d]: got sum=%h cout=%b ovf=%b want 0 0 0",
                         k, sum_v[k], cout_v[k], ovf_v[k]);
            end
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done_v[0] || done_v[1]) nd++;
            tick();
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done cycles want 0", nd);
        end
        run_op(16'h1111, 16'h2222, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (done_n[k] !== 1 || sum_r[k] !== 16'h3334 || cout_r[k] !== 1'b0 || ovf_r[k] !== 1'b0) begin
                errors++;
                $display("FAIL after_abort[%0d]: got done=%0d sum=%h cout=%b ovf=%b want 1 3334 0 0",
                         k, done_n[k], sum_r[k], cout_r[k], ovf_r[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          nd = 0;
        int          first = -1;
        int          second = -1;
        logic [15:0] s1 = 16'h0000;
        logic [15:0] s2 = 16'h0000;
        logic        c2 = 1'b0;
        logic        o2 = 1'b0;
        a_i = 16'h0003; b_i = 16'h0004; sub_i = 1'b0; cin_i = 1'b0; start_i = 1'b1;
        tick();
        for (int cyc = 0; cyc < 20; cyc++) begin
            start_i = 1'b0;
            if (done_v[0]) begin
                nd++;
                if (first < 0) begin
                    first = cyc; s1 = sum_v[0];
                    a_i = 16'h0100; b_i = 16'h0001; sub_i = 1'b1; start_i = 1'b1;
                end else begin
                    second = cyc; s2 = sum_v[0]; c2 = cout_v[0]; o2 = ovf_v[0];
                end
            end
            tick();
        end
        checks++;
        if (nd !== 2 || second - first !== 5) begin
            errors++;
            $display("FAIL b2b_timing: got %0d dones spaced %0d want 2 spaced 5", nd, second - first);
        end
        checks++;
        if (s1 !== 16'h0007) begin
            errors++;
            $display("FAIL b2b_first: got sum=%h want 0007", s1);
        end
        checks++;
        if (s2 !== 16'h00FF || c2 !== 1'b1 || o2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got sum=%h cout=%b ovf=%b want 00ff 1 0", s2, c2, o2);
        end
        repeat (25) tick();
    endtask

    task automatic test_random();
        logic [15:0] ra, rb;
        logic        rs, rc, eo;
        logic [16:0] full;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, rc);
            if (rs) begin
                full = {1'b0, ra} - {1'b0, rb} + 17'h10000;
                eo = (ra[15] != rb[15]) && (full[15] != ra[15]);
            end else begin
                full = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
                eo = (ra[15] == rb[15]) && (full[15] != ra[15]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (done_n[k] !== 1 || sum_r[k] !== full[15:0] || cout_r[k] !== full[16] || ovf_r[k] !== eo) begin
                    errors++;
                    $display("FAIL random[%0d] #%0d a=%h b=%h sub=%b cin=%b: got done=%0d sum=%h cout=%b ovf=%b want 1 %h %b %b",
                             k, i, ra, rb, rs, rc, done_n[k], sum_r[k], cout_r[k], ovf_r[k], full[15:0], full[16], eo);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_in_run();
        test_rst_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
